// File: rtl/stat_dump_uart.sv
// Statistics dump transmitter: snapshots five 32-bit counters on request and sends them
// as one 22-byte UART 8N1 frame (header, 20 big-endian data bytes, XOR checksum).
module stat_dump_uart #(
   parameter int         CLK_DIV = 868,
   parameter logic [7:0] HEADER  = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] total_cycles,
   input  logic [31:0] uncondi_num,
   input  logic [31:0] condi_num,
   input  logic [31:0] condi_suc_num,
   input  logic [31:0] syscall_out,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
   localparam logic [4:0]  LAST_IDX  = 5'd21;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   // Byte idx of the frame: 0 header, 1..20 snapshot MSB-first, 21 checksum.
   function automatic logic [7:0] frame_byte(input logic [159:0] snap,
                                             input logic [4:0]   idx,
                                             input logic [7:0]   csum);
      logic [7:0]   amt;
      logic [159:0] sh;
      amt = 8'd160 - {idx, 3'b000};
      sh  = snap >> amt;
      if (idx == 5'd0) begin
         frame_byte = HEADER;
      end else if (idx <= 5'd20) begin
         frame_byte = sh[7:0];
      end else begin
         frame_byte = csum;
      end
   endfunction

   state_t         state_r, state_nx_s;
   logic [15:0]    baud_r, baud_nx_s;
   logic [2:0]     bit_r, bit_nx_s;
   logic [4:0]     idx_r, idx_nx_s;
   logic [7:0]     csum_r, csum_nx_s;
   logic [159:0]   snap_r;
   logic           tx_r, tx_nx_s;
   logic           busy_r, busy_nx_s;
   logic           done_r, done_nx_s;
   logic           load_s;
   logic           baud_end_s;
   logic [7:0]     cur_byte_s;

   assign cur_byte_s = frame_byte(snap_r, idx_r, csum_r);
   assign baud_end_s = (baud_r == BAUD_LAST);

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_nx_s = state_r;
      baud_nx_s  = baud_r;
      bit_nx_s   = bit_r;
      idx_nx_s   = idx_r;
      csum_nx_s  = csum_r;
      tx_nx_s    = tx_r;
      busy_nx_s  = busy_r;
      done_nx_s  = 1'b0;
      load_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               load_s     = 1'b1;
               state_nx_s = ST_START;
               baud_nx_s  = 16'd0;
               bit_nx_s   = 3'd0;
               idx_nx_s   = 5'd0;
               csum_nx_s  = 8'd0;
               tx_nx_s    = 1'b0;
               busy_nx_s  = 1'b1;
            end else begin
               tx_nx_s    = 1'b1;
               busy_nx_s  = 1'b0;
            end
         end
         ST_START: begin
            if (baud_end_s) begin
               baud_nx_s  = 16'd0;
               bit_nx_s   = 3'd0;
               state_nx_s = ST_DATA;
               tx_nx_s    = cur_byte_s[0];
            end else begin
               baud_nx_s  = baud_r + 16'd1;
            end
         end
         ST_DATA: begin
            if (baud_end_s) begin
               baud_nx_s = 16'd0;
               if (bit_r == 3'd7) begin
                  state_nx_s = ST_STOP;
                  tx_nx_s    = 1'b1;
               end else begin
                  bit_nx_s   = bit_r + 3'd1;
                  tx_nx_s    = cur_byte_s[bit_r + 3'd1];
               end
            end else begin
               baud_nx_s = baud_r + 16'd1;
            end
         end
         ST_STOP: begin
            if (baud_end_s) begin
               baud_nx_s = 16'd0;
               if (idx_r != LAST_IDX) begin
                  // Header is excluded from the checksum.
                  if (idx_r != 5'd0) begin
                     csum_nx_s = csum_r ^ cur_byte_s;
                  end else begin
                     csum_nx_s = csum_r;
                  end
                  idx_nx_s   = idx_r + 5'd1;
                  state_nx_s = ST_START;
                  tx_nx_s    = 1'b0;
               end else begin
                  state_nx_s = ST_IDLE;
                  busy_nx_s  = 1'b0;
                  done_nx_s  = 1'b1;
                  tx_nx_s    = 1'b1;
               end
            end else begin
               baud_nx_s = baud_r + 16'd1;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            tx_nx_s    = 1'b1;
            busy_nx_s  = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         baud_r  <= 16'd0;
         bit_r   <= 3'd0;
         idx_r   <= 5'd0;
         csum_r  <= 8'd0;
         tx_r    <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         baud_r  <= baud_nx_s;
         bit_r   <= bit_nx_s;
         idx_r   <= idx_nx_s;
         csum_r  <= csum_nx_s;
         tx_r    <= tx_nx_s;
         busy_r  <= busy_nx_s;
         done_r  <= done_nx_s;
      end
   end

   // Snapshot of the statistics taken on the accept edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_r <= 160'd0;
      end else if (load_s) begin
         snap_r <= {total_cycles, uncondi_num, condi_num, condi_suc_num, syscall_out};
      end else begin
         snap_r <= snap_r;
      end
   end

   assign tx   = tx_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_stat_dump_uart.sv
// Self-checking bench for stat_dump_uart with CLK_DIV=4: a mid-bit UART receiver checks
// every frame byte against table-driven expectations, plus timing/abort corner cases.
module tb_stat_dump_uart;

   localparam int DIV   = 4;
   localparam int FRAME = 220 * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] total_cycles = 32'd0;
   logic [31:0] uncondi_num = 32'd0;
   logic [31:0] condi_num = 32'd0;
   logic [31:0] condi_suc_num = 32'd0;
   logic [31:0] syscall_out = 32'd0;
   logic        tx, busy, done;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int cyc      = 0;
   int done_cnt = 0;

   typedef struct packed {
      logic [159:0] words;
      logic [7:0]   csum;
   } vec_t;

   vec_t vecs [4];

   stat_dump_uart #(.CLK_DIV(DIV), .HEADER(8'hA5)) dut (
      .clk(clk), .rst(rst), .start(start),
      .total_cycles(total_cycles), .uncondi_num(uncondi_num), .condi_num(condi_num),
      .condi_suc_num(condi_suc_num), .syscall_out(syscall_out),
      .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [7:0] exp_byte(input vec_t v, input int i);
      if (i == 0) return 8'hA5;
      else if (i <= 20) return v.words[(167 - 8 * i) -: 8];
      else return v.csum;
   endfunction

   // Called at a negedge; finds the start bit then samples each bit mid-way.
   task automatic recv_byte(output logic [7:0] b, output logic ok);
      int   n;
      logic st;
      n = 0;
      b = 8'd0;
      while (tx !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (tx !== 1'b0) begin
         ok = 1'b0;
      end else begin
         repeat (DIV / 2) @(negedge clk);
         st = (tx === 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = tx;
         end
         repeat (DIV) @(negedge clk);
         ok = st && (tx === 1'b1);
      end
   endtask

   task automatic apply_words(input logic [159:0] w);
      {total_cycles, uncondi_num, condi_num, condi_suc_num, syscall_out} = w;
   endtask

   // Pulses start for one cycle, scrambles inputs, checks first-cycle outputs.
   task automatic start_frame(input vec_t v, input logic zero_after, input string tag, output int acc);
      @(negedge clk);
      apply_words(v.words);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      apply_words(zero_after ? 160'd0 : ~v.words);
      acc = cyc;
      chk({tag, " tx low after accept"}, {31'd0, tx}, 32'd0);
      chk({tag, " busy after accept"}, {31'd0, busy}, 32'd1);
   endtask

   // Receives 22 bytes and waits for done; returns at the negedge showing done.
   task automatic do_frame(input vec_t v, input string tag, input int acc);
      logic [7:0] b;
      logic       ok, busy_ok;
      int         n;
      for (int i = 0; i < 22; i++) begin
         recv_byte(b, ok);
         chk($sformatf("%s framing byte%0d", tag, i), {31'd0, ok}, 32'd1);
         chk($sformatf("%s data byte%0d", tag, i), {24'd0, b}, {24'd0, exp_byte(v, i)});
      end
      n = 0;
      busy_ok = 1'b1;
      while (done !== 1'b1 && n < 100) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      chk({tag, " done seen"}, {31'd0, done}, 32'd1);
      chk({tag, " busy held"}, {31'd0, busy_ok}, 32'd1);
      chk({tag, " accept-to-done cycles"}, cyc - acc, FRAME);
      chk({tag, " busy low at done"}, {31'd0, busy}, 32'd0);
      chk({tag, " tx high at done"}, {31'd0, tx}, 32'd1);
   endtask

   initial begin
      int   acc, acc2, dc0;
      logic quiet;

      vecs[0] = '{words: {32'd1, 32'd2, 32'd0, 32'd0, 32'd0}, csum: 8'h03};
      vecs[1] = '{words: {5{32'hDEADBEEF}}, csum: 8'h22};
      vecs[2] = '{words: {32'h01234567, 32'h89ABCDEF, 32'h0, 32'hFFFFFFFF, 32'h80000001}, csum: 8'h81};
      vecs[3] = '{words: {32'd0, 32'd0, 32'd0, 32'd0, 32'h12345678}, csum: 8'h08};

      // Reset state and idle line.
      repeat (3) @(negedge clk);
      chk("reset tx", {31'd0, tx}, 32'd1);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      quiet = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
      end
      chk("idle quiet 100 cycles", {31'd0, quiet}, 32'd1);

      // Table-driven frames; inputs change right after accept.
      for (int k = 0; k < 4; k++) begin
         start_frame(vecs[k], (k == 1), $sformatf("vec%0d", k), acc);
         do_frame(vecs[k], $sformatf("vec%0d", k), acc);
         @(negedge clk);
         chk($sformatf("vec%0d done width", k), {31'd0, done}, 32'd0);
      end

      // Start re-pulsed while busy is ignored.
      dc0 = done_cnt;
      start_frame(vecs[2], 1'b0, "busyign", acc);
      fork
         do_frame(vecs[2], "busyign", acc);
         begin
            repeat (9) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (488) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      quiet = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (busy !== 1'b0 || tx !== 1'b1) quiet = 1'b0;
      end
      chk("busyign no second frame", {31'd0, quiet}, 32'd1);
      chk("busyign done count", done_cnt - dc0, 32'd1);

      // Start held high: next frame accepted on the edge after done.
      @(negedge clk);
      apply_words(vecs[3].words);
      start = 1'b1;
      @(negedge clk);
      acc = cyc;
      chk("b2b first accept tx", {31'd0, tx}, 32'd0);
      do_frame(vecs[3], "b2b1", acc);
      @(negedge clk);
      acc2 = cyc;
      start = 1'b0;
      chk("b2b second accept tx", {31'd0, tx}, 32'd0);
      chk("b2b second accept busy", {31'd0, busy}, 32'd1);
      chk("b2b done spacing", acc2 - acc, FRAME + 1);
      do_frame(vecs[3], "b2b2", acc2);

      // Reset mid-frame aborts without a done pulse.
      start_frame(vecs[1], 1'b0, "abort", acc);
      repeat (299) @(negedge clk);
      dc0 = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort tx", {31'd0, tx}, 32'd1);
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      quiet = 1'b1;
      repeat (1000) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
      end
      chk("abort stays idle", {31'd0, quiet}, 32'd1);
      chk("abort no done", done_cnt - dc0, 32'd0);
      start_frame(vecs[0], 1'b0, "postabort", acc);
      do_frame(vecs[0], "postabort", acc);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
